// File: rtl/rv_target_pkg.sv
// Shared types and constants for the ready/valid target BFM core.
package rv_target_pkg;

  typedef enum logic [1:0] {
    RV_RDY_ALWAYS = 2'd0,
    RV_RDY_GAP    = 2'd1,
    RV_RDY_HOLD   = 2'd2,
    RV_RDY_TOGGLE = 2'd3
  } rv_rdy_mode_e;

  localparam int RV_TARGET_STAT_W = 32;

endpackage

// File: rtl/rv_target_fifo.sv
// Small synchronous FIFO; occupancy counter is the single source of full/empty.
module rv_target_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdat,
  output logic [WIDTH-1:0]         rdat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdat    = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; contents are only observable while count is non-zero.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rv_target_bfm_core.sv
// Ready/valid target BFM core: policy-driven t_ready, FIFO buffering, valid/ack pop side.
// Optional RV_TARGET_STATS_EN adds saturating accepted-beat and stall counters.
module rv_target_bfm_core
  import rv_target_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int GAP_W = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             t_dat,
  input  logic                         t_valid,
  output logic                         t_ready,
  output logic [WIDTH-1:0]             o_dat,
  output logic                         o_valid,
  input  logic                         o_ack,
  input  logic [1:0]                   cfg_mode,
  input  logic [GAP_W-1:0]             cfg_gap,
  output logic [$clog2(DEPTH):0]       o_count
`ifdef RV_TARGET_STATS_EN
  ,
  output logic [RV_TARGET_STAT_W-1:0]  o_beats,
  output logic [RV_TARGET_STAT_W-1:0]  o_stalls
`endif
);

  rv_rdy_mode_e     mode_q, mode_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             tog_q;
  logic             allow, accept, full, empty;

  // Mode resets to HOLD so t_ready is low on the first cycle after reset in every policy.
  always_comb begin
    allow = 1'b0;
    case (mode_q)
      RV_RDY_ALWAYS: allow = 1'b1;
      RV_RDY_GAP:    allow = (gap_q == '0);
      RV_RDY_HOLD:   allow = 1'b0;
      RV_RDY_TOGGLE: allow = tog_q;
      default:       allow = 1'b0;
    endcase
  end

  assign t_ready = ~full & allow;
  assign accept  = t_valid & t_ready;
  assign o_valid = ~empty;
  assign mode_d  = rv_rdy_mode_e'(cfg_mode);

  always_comb begin
    gap_d = gap_q;
    if (mode_d != RV_RDY_GAP)  gap_d = '0;
    else if (accept)           gap_d = cfg_gap;
    else if (gap_q != '0)      gap_d = gap_q - GAP_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= RV_RDY_HOLD;
      gap_q  <= '0;
      tog_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      gap_q  <= gap_d;
      tog_q  <= ~tog_q;
    end
  end

  rv_target_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .pop   (o_ack),
    .wdat  (t_dat),
    .rdat  (o_dat),
    .count (o_count),
    .full  (full),
    .empty (empty)
  );

`ifdef RV_TARGET_STATS_EN
  logic [RV_TARGET_STAT_W-1:0] beats_q, stalls_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (accept && beats_q != '1)                  beats_q  <= beats_q + RV_TARGET_STAT_W'(1);
      if (t_valid && !t_ready && stalls_q != '1)    stalls_q <= stalls_q + RV_TARGET_STAT_W'(1);
    end
  end

  assign o_beats  = beats_q;
  assign o_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_rv_target_bfm_core.sv
// Scoreboard bench for rv_target_bfm_core: cycle model of the ready policy plus data queue.
module tb_rv_target_bfm_core;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int GAP_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] t_dat = '0;
  logic             t_valid = 1'b0;
  logic             t_ready;
  logic [WIDTH-1:0] o_dat;
  logic             o_valid;
  logic             o_ack = 1'b0;
  logic [1:0]       cfg_mode = 2'd0;
  logic [GAP_W-1:0] cfg_gap = '0;
  logic [CW-1:0]    o_count;
`ifdef RV_TARGET_STATS_EN
  logic [31:0]      o_beats, o_stalls;
`endif

  rv_target_bfm_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .t_dat    (t_dat),
    .t_valid  (t_valid),
    .t_ready  (t_ready),
    .o_dat    (o_dat),
    .o_valid  (o_valid),
    .o_ack    (o_ack),
    .cfg_mode (cfg_mode),
    .cfg_gap  (cfg_gap),
    .o_count  (o_count)
`ifdef RV_TARGET_STATS_EN
    ,
    .o_beats  (o_beats),
    .o_stalls (o_stalls)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reference model: expected ready from policy state, expected data from a queue.
  int               m_cnt;
  logic [GAP_W-1:0] m_gap;
  logic             m_tog, m_first;
  logic [1:0]       m_mode;
  logic [31:0]      m_beats, m_stalls;
  logic [WIDTH-1:0] sb [$];
  logic             m_allow, exp_rdy, m_acc, m_pop;

  always_comb begin
    case (m_mode)
      2'd0:    m_allow = 1'b1;
      2'd1:    m_allow = (m_gap == '0);
      2'd2:    m_allow = 1'b0;
      default: m_allow = m_tog;
    endcase
    exp_rdy = !m_first && (m_cnt < DEPTH) && m_allow;
    m_acc   = t_valid && exp_rdy;
    m_pop   = o_ack && (m_cnt != 0);
  end

  always @(posedge clock) begin
    if (reset) begin
      m_cnt    <= 0;
      m_gap    <= '0;
      m_tog    <= 1'b0;
      m_first  <= 1'b1;
      m_mode   <= 2'd2;
      m_beats  <= '0;
      m_stalls <= '0;
      sb.delete();
    end else begin
      m_cnt   <= m_cnt + int'(m_acc) - int'(m_pop);
      if (m_pop) void'(sb.pop_front());
      if (m_acc) sb.push_back(t_dat);
      m_tog   <= ~m_tog;
      m_first <= 1'b0;
      m_mode  <= cfg_mode;
      if (cfg_mode != 2'd1)   m_gap <= '0;
      else if (m_acc)         m_gap <= cfg_gap;
      else if (m_gap != '0)   m_gap <= m_gap - 1'b1;
      if (m_acc && m_beats != '1)                  m_beats  <= m_beats + 1;
      if (t_valid && !exp_rdy && m_stalls != '1)   m_stalls <= m_stalls + 1;
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      chk("rdy", t_ready, exp_rdy);
      chk("vld", o_valid, m_cnt != 0);
      chk("cnt", o_count, m_cnt);
      if (m_cnt != 0 && sb.size() > 0) chk("dat", o_dat, sb[0]);
`ifdef RV_TARGET_STATS_EN
      chk("beats", o_beats, m_beats);
      chk("stalls", o_stalls, m_stalls);
`endif
    end
  end

  initial begin
    int n;
    logic [WIDTH-1:0] s1 [3];
    s1[0] = 32'h11; s1[1] = 32'h22; s1[2] = 32'h33;

    @(posedge clock);
    #1 mon_en = 1'b1;
    cyc(1);
    chk("rst_cnt", o_count, 0);
    chk("rst_rdy", t_ready, 0);
    chk("rst_vld", o_valid, 0);

    // 1: ALWAYS, back-to-back, host always acks
    reset = 1'b0; o_ack = 1'b1; cfg_mode = 2'd0;
    cyc(1);
    foreach (s1[i]) begin
      t_valid = 1'b1; t_dat = s1[i];
      cyc(1);
      chk("s1_dat", o_dat, s1[i]);
      chk("s1_cnt", o_count, 1);
    end
    t_valid = 1'b0;
    cyc(3);

    // 2: fill to full, one pop reopens ready
    o_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t_valid = 1'b1; t_dat = 32'hA0 + i;
      cyc(1);
    end
    chk("s2_full", o_count, DEPTH);
    chk("s2_rdy0", t_ready, 0);
    cyc(1);
    o_ack = 1'b1;
    cyc(1);
    o_ack = 1'b0;
    chk("s2_reopen", t_ready, 1);
    cyc(1);
    chk("s2_refull", o_count, DEPTH);
    t_valid = 1'b0;
`ifdef RV_TARGET_STATS_EN
    chk("s2_stalls", o_stalls, 3);
`endif
    o_ack = 1'b1;
    cyc(6);

    // 3: GAP=3 under continuous valid -> one accept every 4 cycles
    cfg_mode = 2'd1; cfg_gap = 8'd3; t_valid = 1'b0;
    cyc(2);
    n = 0;
    t_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t_dat = 32'hB0 + i;
      @(negedge clock);
      if (t_ready) n++;
      @(posedge clock);
      #1;
    end
    chk("s3_acc", n, 4);
    t_valid = 1'b0;
    cyc(5);

    // 4: HOLD drains buffered beats but refuses new ones
    cfg_mode = 2'd0; o_ack = 1'b0;
    cyc(1);
    t_valid = 1'b1; t_dat = 32'hC1;
    cyc(1);
    t_dat = 32'hC2; cfg_mode = 2'd2;
    cyc(1);
    chk("s4_buf", o_count, 2);
    t_dat = 32'hC3; o_ack = 1'b1;
    cyc(4);
    chk("s4_drained", o_count, 0);
    chk("s4_hold", t_ready, 0);
    cfg_mode = 2'd0;
    cyc(1);
    chk("s4_resume", t_ready, 1);
    t_valid = 1'b0;
    cyc(3);

    // 5: TOGGLE after reset: 0,1,0,1...
    reset = 1'b1; cfg_mode = 2'd3;
    cyc(1);
    reset = 1'b0; t_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("s5_tog", t_ready, i % 2);
      t_dat = 32'hD0 + i;
      cyc(1);
    end
    t_valid = 1'b0;
    cyc(4);

    // 6: reset with 3 beats buffered discards them
    cfg_mode = 2'd0; o_ack = 1'b0;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      t_valid = 1'b1; t_dat = 32'hE0 + i;
      cyc(1);
    end
    t_valid = 1'b0;
    chk("s6_pre", o_count, 3);
    reset = 1'b1;
    cyc(1);
    chk("s6_cnt", o_count, 0);
    chk("s6_vld", o_valid, 0);
    chk("s6_rdy", t_ready, 0);
`ifdef RV_TARGET_STATS_EN
    chk("s6_beats", o_beats, 0);
    chk("s6_stalls", o_stalls, 0);
`endif
    reset = 1'b0;
    cyc(3);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
